// File: rtl/cnn_pkg.sv
// Shared sizing helpers and the sequencer state type for the CNN address generators.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Port/counter width: a zero-width bus is never legal, so floor at 1.
    function automatic int bw(input int n);
        int c;
        c = clog2(n);
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int conv_out_dim(input int n, input int k, input int s, input int p);
        return (n + 2 * p - k) / s + 1;
    endfunction

endpackage

// File: rtl/patch_scheduler_nested_wrap_counter.sv
// Four-level wrap counter (level 0 fastest). Exposes the post-increment value so the
// caller can register outputs derived from the next position in the same cycle.
module nested_wrap_counter
    import cnn_pkg::*;
#(
    parameter  int L0 = 3,
    parameter  int L1 = 3,
    parameter  int L2 = 5,
    parameter  int L3 = 5,
    localparam int W0 = bw(L0),
    localparam int W1 = bw(L1),
    localparam int W2 = bw(L2),
    localparam int W3 = bw(L3)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [W0-1:0] o_n0,
    output logic [W1-1:0] o_n1,
    output logic [W2-1:0] o_n2,
    output logic [W3-1:0] o_n3,
    output logic [3:0]    o_wrap
);

    logic [W0-1:0] r_c0;
    logic [W1-1:0] r_c1;
    logic [W2-1:0] r_c2;
    logic [W3-1:0] r_c3;
    logic [3:0]    w_term;

    assign w_term[0] = (r_c0 == W0'(L0 - 1));
    assign w_term[1] = (r_c1 == W1'(L1 - 1));
    assign w_term[2] = (r_c2 == W2'(L2 - 1));
    assign w_term[3] = (r_c3 == W3'(L3 - 1));

    // A level wraps when it is terminal and the carry reaches it.
    assign o_wrap[0] = i_inc & w_term[0];
    assign o_wrap[1] = o_wrap[0] & w_term[1];
    assign o_wrap[2] = o_wrap[1] & w_term[2];
    assign o_wrap[3] = o_wrap[2] & w_term[3];

    always_comb begin
        o_n0 = r_c0;
        o_n1 = r_c1;
        o_n2 = r_c2;
        o_n3 = r_c3;
        if (i_clr) begin
            o_n0 = '0;
            o_n1 = '0;
            o_n2 = '0;
            o_n3 = '0;
        end else begin
            if (i_inc)     o_n0 = w_term[0] ? '0 : r_c0 + W0'(1);
            if (o_wrap[0]) o_n1 = w_term[1] ? '0 : r_c1 + W1'(1);
            if (o_wrap[1]) o_n2 = w_term[2] ? '0 : r_c2 + W2'(1);
            if (o_wrap[2]) o_n3 = w_term[3] ? '0 : r_c3 + W3'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_c0 <= '0;
            r_c1 <= '0;
            r_c2 <= '0;
            r_c3 <= '0;
        end else begin
            r_c0 <= o_n0;
            r_c1 <= o_n1;
            r_c2 <= o_n2;
            r_c3 <= o_n3;
        end
    end

endmodule

// File: rtl/patch_scheduler.sv
// Walks a KxK window over an HxW image (stride S, padding P) and streams one tap
// address per accepted beat, patch after patch in row-major order.
//
// state | meaning
// IDLE  | waiting for i_start; counters parked at zero
// RUN   | presenting beats; advance on o_out_valid & i_out_ready
// DONE  | one-cycle completion pulse, then back to IDLE
module patch_scheduler
    import cnn_pkg::*;
#(
    parameter  int H   = 5,
    parameter  int W   = 5,
    parameter  int K   = 3,
    parameter  int S   = 1,
    parameter  int P   = 1,
    localparam int OH  = conv_out_dim(H, K, S, P),
    localparam int OW  = conv_out_dim(W, K, S, P),
    localparam int AW  = bw(H * W),
    localparam int TW  = bw(K * K),
    localparam int OHW = bw(OH),
    localparam int OWW = bw(OW)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [AW-1:0]  o_out_addr,
    output logic           o_out_pad,
    output logic [TW-1:0]  o_out_tap,
    output logic [OHW-1:0] o_out_oi,
    output logic [OWW-1:0] o_out_oj,
    output logic           o_out_first,
    output logic           o_out_last,
    output logic           o_out_eof
);

    localparam int KW = bw(K);
    localparam int CW = clog2(max2(H, W) + P) + 2;
    localparam logic signed [CW-1:0] HS = CW'(H);
    localparam logic signed [CW-1:0] WS = CW'(W);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic           w_accept;
    logic           w_load;
    logic           w_clr_out;
    logic           w_cnt_clr;
    logic           w_cnt_inc;
    logic [3:0]     w_wrap;

    logic [KW-1:0]  w_n_kj;
    logic [KW-1:0]  w_n_ki;
    logic [OWW-1:0] w_n_oj;
    logic [OHW-1:0] w_n_oi;

    int                    w_row_i;
    int                    w_col_i;
    logic signed [CW-1:0]  w_row;
    logic signed [CW-1:0]  w_col;
    logic                  w_pad;
    logic [AW-1:0]         w_addr;
    logic [TW-1:0]         w_tap;
    logic                  w_first;
    logic                  w_last;
    logic                  w_eof;

    logic [AW-1:0]  r_addr;
    logic           r_pad;
    logic [TW-1:0]  r_tap;
    logic [OHW-1:0] r_oi;
    logic [OWW-1:0] r_oj;
    logic           r_first;
    logic           r_last;
    logic           r_eof;

    nested_wrap_counter #(
        .L0 (K),
        .L1 (K),
        .L2 (OW),
        .L3 (OH)
    ) u_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_cnt_inc),
        .o_n0   (w_n_kj),
        .o_n1   (w_n_ki),
        .o_n2   (w_n_oj),
        .o_n3   (w_n_oi),
        .o_wrap (w_wrap)
    );

    assign o_out_valid = (r_state == RUN);
    assign o_busy      = (r_state == RUN) || (r_state == DONE);
    assign o_done      = (r_state == DONE);
    assign w_accept    = o_out_valid & i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clr_out   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = RUN;
                    w_cnt_clr   = 1'b1;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (w_accept) begin
                    w_cnt_inc = 1'b1;
                    // Every level wrapping together means the eof beat just left.
                    if (&w_wrap) begin
                        w_state_nxt = DONE;
                        w_clr_out   = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath runs on the counter's next position so the outputs land registered.
    always_comb begin
        w_row_i = int'(w_n_oi) * S - P + int'(w_n_ki);
        w_col_i = int'(w_n_oj) * S - P + int'(w_n_kj);
        w_row   = CW'(w_row_i);
        w_col   = CW'(w_col_i);
        w_pad   = (w_row < 0) || (w_row >= HS) || (w_col < 0) || (w_col >= WS);
        w_addr  = w_pad ? '0 : AW'(int'(w_row) * W + int'(w_col));
        w_tap   = TW'(int'(w_n_ki) * K + int'(w_n_kj));
        w_first = (w_n_ki == '0) && (w_n_kj == '0);
        w_last  = (w_n_ki == KW'(K - 1)) && (w_n_kj == KW'(K - 1));
        w_eof   = w_last && (w_n_oi == OHW'(OH - 1)) && (w_n_oj == OWW'(OW - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_clr_out) begin
            r_addr  <= '0;
            r_pad   <= 1'b0;
            r_tap   <= '0;
            r_oi    <= '0;
            r_oj    <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_eof   <= 1'b0;
        end else if (w_load) begin
            r_addr  <= w_addr;
            r_pad   <= w_pad;
            r_tap   <= w_tap;
            r_oi    <= w_n_oi;
            r_oj    <= w_n_oj;
            r_first <= w_first;
            r_last  <= w_last;
            r_eof   <= w_eof;
        end
    end

    assign o_out_addr  = r_addr;
    assign o_out_pad   = r_pad;
    assign o_out_tap   = r_tap;
    assign o_out_oi    = r_oi;
    assign o_out_oj    = r_oj;
    assign o_out_first = r_first;
    assign o_out_last  = r_last;
    assign o_out_eof   = r_eof;

endmodule

// File: tb/tb_patch_scheduler.sv
// Bench for patch_scheduler: two configurations (S=1,P=1 and S=2,P=0) checked beat by
// beat against a reference list built from the window arithmetic.
module tb_patch_scheduler;

    typedef struct {
        int addr;
        int pad;
        int tap;
        int oi;
        int oj;
        int first;
        int last;
        int eof;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic ready;
    logic sel_b;
    logic a_start;
    logic b_start;

    assign a_start = start & ~sel_b;
    assign b_start = start & sel_b;

    logic       a_busy, a_done, a_valid, a_pad, a_first, a_last, a_eof;
    logic [4:0] a_addr;
    logic [3:0] a_tap;
    logic [2:0] a_oi, a_oj;

    logic       b_busy, b_done, b_valid, b_pad, b_first, b_last, b_eof;
    logic [4:0] b_addr;
    logic [3:0] b_tap;
    logic [0:0] b_oi, b_oj;

    patch_scheduler dut_a (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (a_start),
        .o_busy      (a_busy),
        .o_done      (a_done),
        .o_out_valid (a_valid),
        .i_out_ready (ready),
        .o_out_addr  (a_addr),
        .o_out_pad   (a_pad),
        .o_out_tap   (a_tap),
        .o_out_oi    (a_oi),
        .o_out_oj    (a_oj),
        .o_out_first (a_first),
        .o_out_last  (a_last),
        .o_out_eof   (a_eof)
    );

    patch_scheduler #(.H(5), .W(5), .K(3), .S(2), .P(0)) dut_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (b_start),
        .o_busy      (b_busy),
        .o_done      (b_done),
        .o_out_valid (b_valid),
        .i_out_ready (ready),
        .o_out_addr  (b_addr),
        .o_out_pad   (b_pad),
        .o_out_tap   (b_tap),
        .o_out_oi    (b_oi),
        .o_out_oj    (b_oj),
        .o_out_first (b_first),
        .o_out_last  (b_last),
        .o_out_eof   (b_eof)
    );

    logic [31:0] obs_valid, obs_busy, obs_done, obs_addr, obs_pad, obs_tap;
    logic [31:0] obs_oi, obs_oj, obs_first, obs_last, obs_eof;

    always_comb begin
        obs_valid = sel_b ? 32'(b_valid) : 32'(a_valid);
        obs_busy  = sel_b ? 32'(b_busy)  : 32'(a_busy);
        obs_done  = sel_b ? 32'(b_done)  : 32'(a_done);
        obs_addr  = sel_b ? 32'(b_addr)  : 32'(a_addr);
        obs_pad   = sel_b ? 32'(b_pad)   : 32'(a_pad);
        obs_tap   = sel_b ? 32'(b_tap)   : 32'(a_tap);
        obs_oi    = sel_b ? 32'(b_oi)    : 32'(a_oi);
        obs_oj    = sel_b ? 32'(b_oj)    : 32'(a_oj);
        obs_first = sel_b ? 32'(b_first) : 32'(a_first);
        obs_last  = sel_b ? 32'(b_last)  : 32'(a_last);
        obs_eof   = sel_b ? 32'(b_eof)   : 32'(a_eof);
    end

    int    checks = 0;
    int    errors = 0;
    beat_t exp_a[$];
    beat_t exp_b[$];
    int    cap[$];
    int    pad_seen;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference stream straight from the window definition.
    task automatic build(input bit to_b, input int h, input int w, input int k,
                         input int s, input int p);
        int    oh, ow, r, c;
        beat_t bt;
        oh = (h + 2 * p - k) / s + 1;
        ow = (w + 2 * p - k) / s + 1;
        for (int oi = 0; oi < oh; oi++)
            for (int oj = 0; oj < ow; oj++)
                for (int ki = 0; ki < k; ki++)
                    for (int kj = 0; kj < k; kj++) begin
                        r        = oi * s - p + ki;
                        c        = oj * s - p + kj;
                        bt.pad   = (r < 0 || r >= h || c < 0 || c >= w) ? 1 : 0;
                        bt.addr  = bt.pad ? 0 : r * w + c;
                        bt.tap   = ki * k + kj;
                        bt.oi    = oi;
                        bt.oj    = oj;
                        bt.first = (ki == 0 && kj == 0) ? 1 : 0;
                        bt.last  = (ki == k - 1 && kj == k - 1) ? 1 : 0;
                        bt.eof   = (bt.last == 1 && oi == oh - 1 && oj == ow - 1) ? 1 : 0;
                        if (to_b) exp_b.push_back(bt);
                        else      exp_a.push_back(bt);
                    end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, obs_valid, 0);
        chk({tag, "_busy"},  obs_busy,  0);
        chk({tag, "_done"},  obs_done,  0);
        chk({tag, "_addr"},  obs_addr,  0);
        chk({tag, "_pad"},   obs_pad,   0);
        chk({tag, "_tap"},   obs_tap,   0);
        chk({tag, "_oi"},    obs_oi,    0);
        chk({tag, "_oj"},    obs_oj,    0);
        chk({tag, "_first"}, obs_first, 0);
        chk({tag, "_last"},  obs_last,  0);
        chk({tag, "_eof"},   obs_eof,   0);
    endtask

    // One frame: pulse start, then track every presented beat (stalled or not)
    // against the reference entry at the current accept count.
    task automatic run_frame(input bit use_b, input int ready_pct,
                             input int abort_at, input int restart_at);
        beat_t cur[$];
        int    n, acc, cyc;
        bit    rdy;
        logic [31:0] a_sav, oi_sav, oj_sav, pad_sav;
        if (use_b) cur = exp_b;
        else       cur = exp_a;
        n = cur.size();
        cap.delete();
        pad_seen = 0;
        sel_b = use_b;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("first_valid", obs_valid, 1);
        chk("first_busy", obs_busy, 1);
        acc = 0;
        cyc = 0;
        while (obs_valid === 32'd1 && cyc < 5000) begin
            if (acc == abort_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk_all_zero("abort");
                step();
                chk_all_zero("abort_idle");
                return;
            end
            if (acc < n) begin
                chk($sformatf("b%0d_addr", acc),  obs_addr,  cur[acc].addr);
                chk($sformatf("b%0d_pad", acc),   obs_pad,   cur[acc].pad);
                chk($sformatf("b%0d_tap", acc),   obs_tap,   cur[acc].tap);
                chk($sformatf("b%0d_oi", acc),    obs_oi,    cur[acc].oi);
                chk($sformatf("b%0d_oj", acc),    obs_oj,    cur[acc].oj);
                chk($sformatf("b%0d_first", acc), obs_first, cur[acc].first);
                chk($sformatf("b%0d_last", acc),  obs_last,  cur[acc].last);
                chk($sformatf("b%0d_eof", acc),   obs_eof,   cur[acc].eof);
                chk($sformatf("b%0d_done", acc),  obs_done,  0);
            end else begin
                chk("extra_beat", acc, n);
            end
            a_sav   = obs_addr;
            oi_sav  = obs_oi;
            oj_sav  = obs_oj;
            pad_sav = obs_pad;
            rdy   = ($urandom_range(99) < ready_pct);
            ready = rdy;
            start = (acc == restart_at);
            step();
            cyc++;
            start = 1'b0;
            if (rdy) begin
                if (oi_sav == 1 && oj_sav == 1) cap.push_back(int'(a_sav));
                if (pad_sav == 1) pad_seen++;
                acc++;
            end
        end
        ready = 1'b1;
        chk("frame_budget", (cyc < 5000) ? 1 : 0, 1);
        chk("beat_count", acc, n);
        chk("done_pulse", obs_done, 1);
        chk("done_busy", obs_busy, 1);
        chk("done_valid", obs_valid, 0);
        step();
        chk("after_done", obs_done, 0);
        chk("after_busy", obs_busy, 0);
        chk("after_valid", obs_valid, 0);
    endtask

    int patch_a[9];
    int patch_b[9];

    task automatic chk_patch(input bit use_b);
        chk("patch_len", cap.size(), 9);
        for (int i = 0; i < 9 && i < cap.size(); i++)
            chk($sformatf("patch_addr%0d", i), cap[i], use_b ? patch_b[i] : patch_a[i]);
    endtask

    initial begin
        patch_a = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        patch_b = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        sel_b = 1'b0;
        repeat (3) step();
        chk_all_zero("reset_a");
        sel_b = 1'b1;
        chk_all_zero("reset_b");
        sel_b = 1'b0;
        rst = 1'b0;
        step();

        build(1'b0, 5, 5, 3, 1, 1);
        build(1'b1, 5, 5, 3, 2, 0);

        run_frame(1'b0, 100, -1, -1);
        chk_patch(1'b0);

        run_frame(1'b1, 100, -1, -1);
        chk_patch(1'b1);
        chk("b_pad_beats", pad_seen, 0);

        run_frame(1'b0, 50, -1, 50);
        chk_patch(1'b0);

        run_frame(1'b0, 100, 100, -1);
        run_frame(1'b0, 100, -1, -1);
        chk_patch(1'b0);

        run_frame(1'b1, 50, -1, 10);
        chk_patch(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/patch_scheduler.md
Name: patch_scheduler

Overview:
- Sequencer that walks a conv window over an HxW single-channel image, with padding P and stride S.
- For each output position (oi,oj), it emits the K*K tap addresses of that patch in row-major order, one beat per cycle, over a valid/ready stream.
- Feeds the image-buffer read port and the MAC array. Produces the same window that the combinational patch extractor yields at I=oi, J=oj, but as a sequenced, flow-controlled address stream.

Parameters:
- H, 5, image height in pixels
- W, 5, image width in pixels
- K, 3, kernel side (K*K taps per patch)
- S, 1, stride, >=1
- P, 1, zero-padding on each border, >=0
- Derived (localparam): OH=(H+2P-K)/S+1, OW=(W+2P-K)/S+1 (floor division)
- Derived (localparam): AW=clog2(H*W), CW=clog2(max(H,W)+P)+2 (signed coordinate width)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final beat is accepted
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- out_addr  out  AW  linear pixel address r*W+c; 0 when out_pad=1
- out_pad  out  1  tap lies in the padding region; downstream substitutes 0
- out_tap  out  clog2(K*K)  tap index ki*K+kj
- out_oi  out  clog2(OH)  output row of current patch
- out_oj  out  clog2(OW)  output column of current patch
- out_first  out  1  tap 0 of a patch
- out_last  out  1  tap K*K-1 of a patch
- out_eof  out  1  last tap of the last patch (oi=OH-1, oj=OW-1)

Behaviour:
- Reset: state IDLE. All outputs 0, all counters 0. Reset mid-frame aborts immediately, with no done pulse.
- FSM states:
  - IDLE -> RUN when start=1. start is ignored in RUN and DONE.
  - RUN -> DONE when the beat with out_eof=1 is accepted.
  - DONE -> IDLE unconditionally after one cycle. done=1 only in DONE.
- busy=1 in RUN and DONE.
- out_valid=1 exactly while in RUN. The first beat appears the cycle after start (latency 1).
- Coordinates, computed in signed CW-bit arithmetic:
  - r = oi*S - P + ki
  - c = oj*S - P + kj
- Padding: out_pad = (r<0)|(r>=H)|(c<0)|(c>=W). out_addr = r*W + c when out_pad=0, else 0.
- Outputs are registered and change only on the cycle after an accepted beat. All outputs hold stable while out_valid=1 and out_ready=0.
- Advance on out_valid&out_ready, as a nested wrap:
  - kj++, wrapping to 0 at K
  - then ki++, wrapping at K
  - then oj++, wrapping at OW
  - then oi++
- One beat per cycle under continuous out_ready, with no bubbles between patches.
- Total beats per frame = OH*OW*K*K.
- Degenerate K=1, P=0: every beat has out_first=out_last=1.
- out_eof implies out_last.

Decomposition:
- Shared package cnn_pkg holds:
  - function clog2
  - function conv_out_dim(n,k,s,p)
  - FSM state enum (IDLE, RUN, DONE)
- One natural sub-module: nested_wrap_counter. It is a 4-level parameterised wrap counter (limits K,K,OW,OH), with an increment enable and per-level wrap/terminal flags.
- patch_scheduler instantiates one nested_wrap_counter and contains the FSM plus the coordinate/address datapath.

Test Plan:
- Defaults (H=W=5, K=3, S=1, P=1), out_ready=1, pulse start:
  - first beat the cycle after start: oi=oj=0, tap0, r=c=-1, out_pad=1, out_addr=0, out_first=1
  - frame is 225 beats
  - out_eof on beat 224
  - done pulses exactly once, one cycle later
- Same config, capture patch oi=1, oj=1:
  - 9 beats, all out_pad=0
  - out_addr = 0,1,2,5,6,7,10,11,12
  - out_first on tap 0, out_last on tap 8
- S=2, P=0, H=W=5, K=3:
  - OH=OW=2, 36 beats, no pad beats
  - patch (1,1) addresses = 12,13,14,17,18,19,22,23,24
- Backpressure: random out_ready (~50%):
  - outputs stable whenever out_valid&!out_ready
  - sequence identical to the no-stall run
  - done still a single pulse
- start pulsed again mid-frame -> ignored; beat count unchanged. After done, a new start restarts from oi=oj=0.
- rst asserted at beat 100:
  - next cycle out_valid=0, busy=0, done=0, all outputs 0
  - a subsequent start yields a full 225-beat frame from tap 0
